// File: rtl/traffic_phase_fsm.sv
// Traffic phase controller: sequences main/side/walk phases against an interval timer.
// Optional pedestrian phase is enabled by defining TRAFFIC_WALK_EN.
module traffic_phase_fsm #(
  parameter int T_BASE = 6,
  parameter int T_EXT  = 3,
  parameter int T_YEL  = 2
) (
  input  logic       clk,
  input  logic       Reset_Sync,
  input  logic       Sensor_Sync,
  input  logic       WR_Sync,
  input  logic       expired,
  output logic [3:0] Value,
  output logic       start_timer,
  output logic       WR_Reset,
  output logic [2:0] Main_RYG,
  output logic [2:0] Side_RYG,
  output logic       Walk
);

  if ((T_BASE < 1) || (T_BASE > 15) ||
      (T_EXT  < 1) || (T_EXT  > 15) ||
      (T_YEL  < 1) || (T_YEL  > 15)) begin : g_bad_param
    $error("traffic_phase_fsm: T_* must be in 1..15");
  end

  localparam logic [3:0] V_BASE = 4'(T_BASE);
  localparam logic [3:0] V_EXT  = 4'(T_EXT);
  localparam logic [3:0] V_YEL  = 4'(T_YEL);

  localparam logic [2:0] LR = 3'b100;
  localparam logic [2:0] LY = 3'b010;
  localparam logic [2:0] LG = 3'b001;

  typedef enum logic [2:0] {
    MG_A = 3'd0,
    MG_B = 3'd1,
    MY   = 3'd2,
`ifdef TRAFFIC_WALK_EN
    WALK = 3'd3,
`endif
    SG   = 3'd4,
    SG_X = 3'd5,
    SY   = 3'd6
  } state_t;

  state_t     state_q;
  state_t     state_d;
  logic [1:0] age_q;
  logic       adv;

  logic [3:0] value_d;
  logic [2:0] main_d;
  logic [2:0] side_d;
  logic       walk_d;
  logic       enter_walk;

  // Expiry is honoured only once the start and load cycles have passed
  assign adv = expired && (age_q == 2'd2);

`ifdef TRAFFIC_WALK_EN
  logic walk_pending;

  assign enter_walk = adv && (state_d == WALK);

  always_ff @(posedge clk) begin
    if (Reset_Sync) begin
      walk_pending <= 1'b0;
    end else if (enter_walk) begin
      walk_pending <= 1'b0;
    end else if (WR_Sync) begin
      walk_pending <= 1'b1;
    end
  end
`else
  logic wr_unused;

  assign wr_unused  = WR_Sync;
  assign enter_walk = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (Reset_Sync) begin
      state_q <= MG_A;
      age_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      if (adv) begin
        age_q <= 2'd0;
      end else if (age_q != 2'd2) begin
        age_q <= age_q + 2'd1;
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (adv) begin
      unique case (state_q)
        MG_A: state_d = MG_B;
        MG_B: state_d = MY;
`ifdef TRAFFIC_WALK_EN
        MY:   state_d = walk_pending ? WALK : SG;
        WALK: state_d = SG;
`else
        MY:   state_d = SG;
`endif
        SG:   state_d = Sensor_Sync ? SG_X : SY;
        SG_X: state_d = SY;
        SY:   state_d = MG_A;
        default: state_d = MG_A;
      endcase
    end
  end

  // Output logic, decoded from the next state and registered below
  always_comb begin
    value_d = Value;
    main_d  = LR;
    side_d  = LR;
    walk_d  = 1'b0;
    unique case (state_d)
      MG_A: begin
        main_d = LG;
        if (adv) value_d = V_BASE;
      end
      MG_B: begin
        main_d = LG;
        if (adv) value_d = Sensor_Sync ? V_EXT : V_BASE;
      end
      MY: begin
        main_d = LY;
        if (adv) value_d = V_YEL;
      end
`ifdef TRAFFIC_WALK_EN
      WALK: begin
        walk_d = 1'b1;
        if (adv) value_d = V_EXT;
      end
`endif
      SG: begin
        side_d = LG;
        if (adv) value_d = V_BASE;
      end
      SG_X: begin
        side_d = LG;
        if (adv) value_d = V_EXT;
      end
      SY: begin
        side_d = LY;
        if (adv) value_d = V_YEL;
      end
      default: begin
        main_d  = LG;
        value_d = V_BASE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (Reset_Sync) begin
      Value       <= V_BASE;
      Main_RYG    <= LG;
      Side_RYG    <= LR;
      Walk        <= 1'b0;
      start_timer <= 1'b0;
      WR_Reset    <= 1'b0;
    end else begin
      Value       <= value_d;
      Main_RYG    <= main_d;
      Side_RYG    <= side_d;
      Walk        <= walk_d;
      start_timer <= adv;
      WR_Reset    <= enter_walk;
    end
  end

endmodule

// File: tb/tb_traffic_phase_fsm.sv
// Directed bench for traffic_phase_fsm.
// Expectations follow TRAFFIC_WALK_EN when it is defined.
module tb_traffic_phase_fsm;

  localparam logic [2:0] LR = 3'b100;
  localparam logic [2:0] LY = 3'b010;
  localparam logic [2:0] LG = 3'b001;

  logic       clk = 1'b0;
  logic       Reset_Sync = 1'b1;
  logic       Sensor_Sync = 1'b0;
  logic       WR_Sync = 1'b0;
  logic       expired = 1'b0;
  logic [3:0] Value;
  logic       start_timer;
  logic       WR_Reset;
  logic [2:0] Main_RYG;
  logic [2:0] Side_RYG;
  logic       Walk;

  int n_cmp = 0;
  int n_err = 0;

  traffic_phase_fsm dut (
    .clk         (clk),
    .Reset_Sync  (Reset_Sync),
    .Sensor_Sync (Sensor_Sync),
    .WR_Sync     (WR_Sync),
    .expired     (expired),
    .Value       (Value),
    .start_timer (start_timer),
    .WR_Reset    (WR_Reset),
    .Main_RYG    (Main_RYG),
    .Side_RYG    (Side_RYG),
    .Walk        (Walk)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string tag, logic [7:0] got, logic [7:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_all(string tag, logic [3:0] v, logic [2:0] m,
                         logic [2:0] s, logic w, logic wrr, logic st);
    chk({tag, ".value"}, 8'(Value), 8'(v));
    chk({tag, ".main"}, 8'(Main_RYG), 8'(m));
    chk({tag, ".side"}, 8'(Side_RYG), 8'(s));
    chk({tag, ".walk"}, 8'(Walk), 8'(w));
    chk({tag, ".wrr"}, 8'(WR_Reset), 8'(wrr));
    chk({tag, ".start"}, 8'(start_timer), 8'(st));
  endtask

  // Two idle cycles with the sensor inverted, then an expiry pulse.
  // wr: 0 none, 1 request in first idle cycle, 2 request on the expiry edge.
  task automatic step(string tag, logic sens, int wr, logic [3:0] v,
                      logic [2:0] m, logic [2:0] s, logic w, logic wrr);
    Sensor_Sync = ~sens;
    WR_Sync = (wr == 1);
    tick();
    chk({tag, ".idle_start"}, 8'(start_timer), 8'd0);
    WR_Sync = 1'b0;
    tick();
    Sensor_Sync = sens;
    WR_Sync = (wr == 2);
    expired = 1'b1;
    tick();
    expired = 1'b0;
    WR_Sync = 1'b0;
    chk_all(tag, v, m, s, w, wrr, 1'b1);
  endtask

  initial begin
    // Reset
    tick(); tick(); tick();
    chk_all("rst", 4'd6, LG, LR, 1'b0, 1'b0, 1'b0);
    Reset_Sync = 1'b0;

    // Base cycle
    step("a_mgb", 1'b0, 0, 4'd6, LG, LR, 1'b0, 1'b0);
    step("a_my",  1'b0, 0, 4'd2, LY, LR, 1'b0, 1'b0);
    step("a_sg",  1'b0, 0, 4'd6, LR, LG, 1'b0, 1'b0);
    step("a_sy",  1'b0, 0, 4'd2, LR, LY, 1'b0, 1'b0);
    step("a_mga", 1'b0, 0, 4'd6, LG, LR, 1'b0, 1'b0);

    // Sensor extensions
    step("s_mgb", 1'b1, 0, 4'd3, LG, LR, 1'b0, 1'b0);
    step("s_my",  1'b0, 0, 4'd2, LY, LR, 1'b0, 1'b0);
    step("s_sg",  1'b0, 0, 4'd6, LR, LG, 1'b0, 1'b0);
    step("s_sgx", 1'b1, 0, 4'd3, LR, LG, 1'b0, 1'b0);
    step("s_sy",  1'b0, 0, 4'd2, LR, LY, 1'b0, 1'b0);
    step("s_mga", 1'b0, 0, 4'd6, LG, LR, 1'b0, 1'b0);

    // Walk request pulse during MG_A
    step("w_mgb", 1'b0, 1, 4'd6, LG, LR, 1'b0, 1'b0);
    step("w_my",  1'b0, 0, 4'd2, LY, LR, 1'b0, 1'b0);
`ifdef TRAFFIC_WALK_EN
    step("w_walk", 1'b0, 0, 4'd3, LR, LR, 1'b1, 1'b1);
    tick();
    chk("w_walk2.wrr", 8'(WR_Reset), 8'd0);
    chk("w_walk2.walk", 8'(Walk), 8'd1);
`endif
    step("w_sg",  1'b0, 0, 4'd6, LR, LG, 1'b0, 1'b0);
    step("w_sy",  1'b0, 0, 4'd2, LR, LY, 1'b0, 1'b0);
    step("w_mga", 1'b0, 0, 4'd6, LG, LR, 1'b0, 1'b0);
    step("n_mgb", 1'b0, 0, 4'd6, LG, LR, 1'b0, 1'b0);
    step("n_my",  1'b0, 0, 4'd2, LY, LR, 1'b0, 1'b0);
    step("n_sg",  1'b0, 0, 4'd6, LR, LG, 1'b0, 1'b0);
    step("n_sy",  1'b0, 0, 4'd2, LR, LY, 1'b0, 1'b0);
    step("n_mga", 1'b0, 0, 4'd6, LG, LR, 1'b0, 1'b0);

    // Request on the WALK entry edge must not re-arm the walk
    step("b_mgb", 1'b0, 1, 4'd6, LG, LR, 1'b0, 1'b0);
    step("b_my",  1'b0, 0, 4'd2, LY, LR, 1'b0, 1'b0);
`ifdef TRAFFIC_WALK_EN
    step("b_walk", 1'b0, 2, 4'd3, LR, LR, 1'b1, 1'b1);
    step("b_sg",   1'b0, 0, 4'd6, LR, LG, 1'b0, 1'b0);
`else
    step("b_sg",   1'b0, 2, 4'd6, LR, LG, 1'b0, 1'b0);
`endif
    step("b_sy",  1'b0, 0, 4'd2, LR, LY, 1'b0, 1'b0);
    step("b_mga", 1'b0, 0, 4'd6, LG, LR, 1'b0, 1'b0);
    step("c_mgb", 1'b0, 0, 4'd6, LG, LR, 1'b0, 1'b0);
    step("c_my",  1'b0, 0, 4'd2, LY, LR, 1'b0, 1'b0);

    // Blanking: expiry held high from the MY start cycle
    Sensor_Sync = 1'b0;
    expired = 1'b1;
    tick();
    chk_all("bl1", 4'd2, LY, LR, 1'b0, 1'b0, 1'b0);
    tick();
    chk_all("bl2", 4'd2, LY, LR, 1'b0, 1'b0, 1'b0);
    tick();
    expired = 1'b0;
    chk_all("bl3", 4'd6, LR, LG, 1'b0, 1'b0, 1'b1);

    // Reset during SG_X with a walk request pending
    step("r_sgx", 1'b1, 1, 4'd3, LR, LG, 1'b0, 1'b0);
    tick();
    Reset_Sync = 1'b1;
    tick();
    chk_all("r_rst", 4'd6, LG, LR, 1'b0, 1'b0, 1'b0);
    Reset_Sync = 1'b0;
    step("r_mgb", 1'b0, 0, 4'd6, LG, LR, 1'b0, 1'b0);
    step("r_my",  1'b0, 0, 4'd2, LY, LR, 1'b0, 1'b0);
    step("r_sg",  1'b0, 0, 4'd6, LR, LG, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/traffic_phase_fsm.md
# traffic_phase_fsm

Phase controller driving the interval timer from the other side of its interface. It selects each phase's duration on `Value` and pulses `start_timer` on phase entry. Each `expired` pulse from the timer advances it to the next phase. It drives main-road, side-road and pedestrian lamps from a registered state machine, and sits between the synchronised inputs (sensor, walk button) and the lamp outputs.

## Interface
- `T_BASE`, default 6: base green duration, seconds; legal range 1..15.
- `T_EXT`, default 3: extension/walk duration, seconds; legal range 1..15.
- `T_YEL`, default 2: yellow duration, seconds; legal range 1..15.
- `clk` in 1: system clock.
- `Reset_Sync` in 1: synchronous, active-high reset.
- `Sensor_Sync` in 1: side-road vehicle sensor, already synchronised; level.
- `WR_Sync` in 1: walk request, already synchronised; level or pulse.
- `expired` in 1: one-cycle pulse from the interval timer.
- `Value` out 4: duration of the current phase, to the timer.
- `start_timer` out 1: one-cycle pulse that restarts the timer.
- `WR_Reset` out 1: one-cycle pulse that clears the external walk-button latch.
- `Main_RYG` out 3: main lamps {R,Y,G}.
- `Side_RYG` out 3: side lamps {R,Y,G}.
- `Walk` out 1: pedestrian walk lamp.

## Operation
Phase sequence, with `Value` and lamps per state:
- `MG_A`: `Value` = T_BASE. Main G, side R. On `expired` go to `MG_B`.
- `MG_B`: `Value` = T_EXT if `Sensor_Sync` was high at the `MG_A` expiry, else T_BASE. Main G, side R. On `expired` go to `MY`.
- `MY`: `Value` = T_YEL. Main Y, side R. On `expired`, go to `WALK` if `walk_pending`, else `SG`.
- `WALK`: `Value` = T_EXT. Both roads R, `Walk` = 1. On `expired` go to `SG`.
- `SG`: `Value` = T_BASE. Main R, side G. On `expired`, go to `SG_X` if `Sensor_Sync` is high, else `SY`.
- `SG_X`: `Value` = T_EXT. Main R, side G. On `expired` go to `SY`.
- `SY`: `Value` = T_YEL. Main R, side Y. On `expired` go to `MG_A`.

Walk handling:
- `walk_pending` is a sticky bit, set by `WR_Sync` in any state.
- It is cleared on the edge that enters `WALK`.
- `WR_Reset` pulses in the first cycle of `WALK`.

Boundary rules:
- `WR_Sync` high on the same edge that enters `WALK` leaves `walk_pending` clear; set wins only outside that edge.
- `Sensor_Sync` is sampled only on the deciding `expired` edge. Changes mid-phase have no effect.
- Width: `Value` is 4 bits, and parameters outside 1..15 are illegal. An elaboration-time check fires on T_* = 0 or T_* > 15.

## Timing
Reset:
- While `Reset_Sync` is high: state = `MG_A`, `Value` = T_BASE, Main_RYG = 3'b001, Side_RYG = 3'b100.
- Also during reset: `start_timer` = 0, `WR_Reset` = 0, `Walk` = 0, `walk_pending` = 0.
- The timer reloads itself on `Reset_Sync`, so no start pulse is issued at reset release.
- Reset asserted mid-phase aborts the phase at the next edge, with the values above.

Phase change:
- All outputs are registered.
- On edge N, `expired` = 1 is sampled and the state changes; `Value` and the lamps change on the same edge.
- `start_timer` = 1 for exactly cycle N..N+1, i.e. the first cycle of the new state.
- `Value` is held constant for the whole state, covering the timer's one-cycle load delay.

Blanking:
- `expired` is ignored in the first two cycles of any state (start cycle plus load cycle).
- A pulse there is dropped, not deferred.

Latency: `expired` to lamp change is 1 clock.

## Configuration
`TRAFFIC_WALK_EN` controls the pedestrian phase.
- Defined: `WALK` state, `walk_pending`, `WR_Reset` and `Walk` are implemented as above.
- Undefined:
  - `WALK` and `walk_pending` are removed.
  - `MY` always goes to `SG`.
  - `WR_Sync` is ignored.
  - `WR_Reset` and `Walk` are tied to 0; the ports remain.

## Test plan
- **Reset and base cycle:** Reset_Sync high for 3 clk, then expired pulses with no sensor and no walk request.
  - Required: states MG_A → MG_B → MY → SG → SY → MG_A.
  - Required `Value` per state: 6, 6, 2, 6, 2.
  - Required: one `start_timer` pulse per entry.
- **Sensor in main phase:** Sensor_Sync high at the MG_A expiry.
  - Required: MG_B has `Value` = 3.
  - Required: Sensor_Sync low at the MG_B expiry has no further effect.
- **Side extension:** Sensor_Sync high at the SG expiry.
  - Required: SG_X entered with `Value` = 3, side G held, then SY.
- **Walk request:** 1-cycle WR_Sync pulse during MG_A.
  - Required: MY → WALK with `Walk` = 1, both roads R, `Value` = 3, and `WR_Reset` pulsed once.
  - Required: next cycle goes to SG with no WALK.
  - Repeat with `TRAFFIC_WALK_EN` undefined. Required: no WALK state and `WR_Reset` stays 0.
- **Blanking:** expired asserted in the `start_timer` cycle and in the next cycle.
  - Required: no state change.
  - Required: expired in the 3rd cycle advances the state.
- **Reset mid-phase:** Reset_Sync asserted during SG_X.
  - Required: next edge gives MG_A, `Value` = 6, Main_RYG = 001, Side_RYG = 100, `walk_pending` cleared.
